control_law_sequencer: RTL and testbench
========================================

Name: control_law_sequencer

Overview:
Periodic scheduler and time-multiplexed datapath for the two-term Q16.16 control law b = K1*a1 + K2*a2. A programmable period counter opens one sample window per control period. Inputs are accepted over a valid/ready handshake. Both products are computed sequentially on a single shared 32x32 signed multiplier, then the result is saturated and presented with a one-cycle valid strobe. It sits between the sensor sampling front end and the actuator output register.

Parameters:
K1, -32'sd13107, first gain, signed Q16.16 (-0.2)
K2, -32'sd26214, second gain, signed Q16.16 (-0.4)
PERIOD, 1000, clock cycles per control period (>=8)
SAT_EN, 1, 1 = saturate result to 32 bits; 0 = plain truncation of sum[47:16]

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  enables period counter; 0 holds counter at 0
a1  in  32  signed Q16.16 input 1
a2  in  32  signed Q16.16 input 2
in_valid  in  1  a1/a2 valid
in_ready  out  1  block ready to accept a1/a2
test  in  1  test mode; sampled with inputs at accept
b  out  32  signed Q16.16 result, held between updates
b_valid  out  1  one-cycle strobe when b updates
busy  out  1  high whenever state != IDLE
overrun  out  1  one-cycle pulse when a tick arrives while busy
overrun_cnt  out  16  saturating count of overruns

Behaviour:
- Reset (async, active-high) forces state IDLE, counter 0, and internal accumulator and latches 0. Outputs reset to b=0, b_valid=0, in_ready=0, busy=0, overrun=0, overrun_cnt=0. Reset mid-operation aborts the operation with no b_valid.
- Period counter: while en=1, counts 0..PERIOD-1 and wraps. tick=1 in the cycle where count==PERIOD-1. en=0 clears the counter and suppresses tick; an operation already in flight still completes.
- FSM states: IDLE, WAIT_IN, MUL1, MUL2, OUT.
  - IDLE: tick -> WAIT_IN.
  - WAIT_IN: in_ready=1. On an edge with in_valid&in_ready, latch a1, a2 and test, then go to MUL1. Stays in WAIT_IN indefinitely otherwise.
  - MUL1: acc <= a1*K1, 64-bit signed. Then MUL2.
  - MUL2: acc <= acc + a2*K2, using the same multiplier instance with its operands muxed. Then OUT.
  - OUT: b <= result, b_valid=1 for exactly one cycle. Then IDLE.
- Latency: b and b_valid update on the 3rd rising edge after the accepting edge. Latency is constant, including in test mode.
- Result rules:
  - test latched 1: result = a1 + 32'sh00010000, wrapping 32-bit add, no saturation.
  - test latched 0, SAT_EN=1: if acc[63:47] is not all-equal, result = 0x7FFFFFFF when acc[63]=0, or 0x80000000 when acc[63]=1. Otherwise result = acc[47:16].
  - SAT_EN=0: result = acc[47:16].
- Overrun: tick while state != IDLE (including WAIT_IN and OUT) pulses overrun for 1 cycle and increments overrun_cnt, which saturates at 0xFFFF. The tick is otherwise dropped and the current operation continues unaffected.
- in_valid while in_ready=0 is ignored; nothing is latched.
- Only reset clears overrun_cnt.

Test Plan:
- Defaults; en=1, PERIOD=8; a1=a2=0x00010000, in_valid held 1 -> accept on first tick, b=0xFFFF6667 (-39321) with b_valid 1 cycle on 3rd edge after accept; b held thereafter; busy high from WAIT_IN through OUT.
- K1=K2=0x00010000; a1=a2=0x7FFFFFFF -> b=0x7FFFFFFF. a1=a2=0x80000000 -> b=0x80000000. Same with SAT_EN=0 -> b=0xFFFFFFFE and b=0x00000000 respectively.
- test=1 at accept, a1=0x00020000 -> b=0x00030000, same latency; toggling test after accept has no effect on that result.
- PERIOD=8, in_valid held 0 across two ticks -> overrun pulses once at the second tick, overrun_cnt=1, state remains WAIT_IN; later in_valid=1 completes normally.
- Assert rst during MUL2 -> b=0, no b_valid, state IDLE, counter 0. After release, the next tick restarts cleanly.
- en dropped during MUL1 -> operation completes with b_valid; no further ticks or in_ready until en returns; counter restarts from 0.

Source files
------------

// File: rtl/control_law_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_law_sequencer
// Description : Periodic scheduler and time-multiplexed datapath computing
//               b = K1*a1 + K2*a2 in signed Q16.16 on one shared 32x32
//               multiplier, with optional saturation and overrun tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module control_law_sequencer #(
  parameter logic signed [31:0] K1     = -32'sd13107,
  parameter logic signed [31:0] K2     = -32'sd26214,
  parameter int                 PERIOD = 1000,
  parameter bit                 SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        test,
  output logic [31:0] b,
  output logic        b_valid,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] overrun_cnt
);

  localparam int                 c_cnt_w = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_IN = 3'd1,
    S_MUL1    = 3'd2,
    S_MUL2    = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_cnt_w-1:0]    r_count;
  logic [31:0]           r_a1;
  logic [31:0]           r_a2;
  logic                  r_test;
  logic signed [63:0]    r_acc;
  logic [31:0]           r_b;
  logic                  r_b_valid;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_overrun;
  logic [15:0]           r_overrun_cnt;

  logic                  w_tick;
  logic signed [63:0]    w_mul_a;
  logic signed [63:0]    w_mul_k;
  logic signed [63:0]    w_prod;
  logic                  w_sat_ovf;
  logic [31:0]           w_result;

  // Period counter: free-runs 0..PERIOD-1 while enabled, parked at 0 otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!en) begin
      r_count <= '0;
    end else if (r_count == c_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign w_tick = en && (r_count == c_last);

  // Shared multiplier: operands steered by state, sign-extended to 64 bits
  assign w_mul_a = (r_state == S_MUL2) ? {{32{r_a2[31]}}, r_a2} : {{32{r_a1[31]}}, r_a1};
  assign w_mul_k = (r_state == S_MUL2) ? {{32{K2[31]}}, K2}     : {{32{K1[31]}}, K1};
  assign w_prod  = w_mul_a * w_mul_k;

  // Overflow when the bits above the Q16.16 result window disagree with the sign
  assign w_sat_ovf = (r_acc[63:47] != {17{r_acc[63]}});

  // Result selection: test bypass, saturated or truncated accumulator window
  always_comb begin
    w_result = r_acc[47:16];
    if (r_test) begin
      w_result = r_a1 + 32'h0001_0000;
    end else if (SAT_EN && w_sat_ovf) begin
      w_result = r_acc[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  // Sequencer FSM with registered outputs and overrun accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_a1          <= '0;
      r_a2          <= '0;
      r_test        <= 1'b0;
      r_acc         <= '0;
      r_b           <= '0;
      r_b_valid     <= 1'b0;
      r_in_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_overrun_cnt <= '0;
    end else begin
      r_b_valid <= 1'b0;
      r_overrun <= 1'b0;

      // A tick that finds the sequencer busy is dropped but recorded
      if (w_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
        if (r_overrun_cnt != 16'hFFFF) begin
          r_overrun_cnt <= r_overrun_cnt + 16'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state    <= S_WAIT_IN;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_WAIT_IN: begin
          if (in_valid && r_in_ready) begin
            r_a1       <= a1;
            r_a2       <= a2;
            r_test     <= test;
            r_in_ready <= 1'b0;
            r_state    <= S_MUL1;
          end
        end
        S_MUL1: begin
          r_acc   <= w_prod;
          r_state <= S_MUL2;
        end
        S_MUL2: begin
          r_acc   <= r_acc + w_prod;
          r_state <= S_OUT;
        end
        S_OUT: begin
          r_b       <= w_result;
          r_b_valid <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign b           = r_b;
  assign b_valid     = r_b_valid;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign overrun_cnt = r_overrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_control_law_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_law_sequencer
// Description : Directed self-checking bench for control_law_sequencer. Three
//               instances share stimulus: default gains, unity gains with
//               saturation, unity gains with truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_law_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] a1;
  logic [31:0] a2;
  logic        in_valid;
  logic        test;

  logic        rdy0, bv0, busy0, ov0;
  logic [31:0] b0;
  logic [15:0] oc0;
  logic        rdy1, bv1, busy1, ov1;
  logic [31:0] b1;
  logic [15:0] oc1;
  logic        rdy2, bv2, busy2, ov2;
  logic [31:0] b2;
  logic [15:0] oc2;

  int errors = 0;
  int checks = 0;

  control_law_sequencer #(.PERIOD(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .a1(a1), .a2(a2), .in_valid(in_valid),
    .in_ready(rdy0), .test(test), .b(b0), .b_valid(bv0), .busy(busy0),
    .overrun(ov0), .overrun_cnt(oc0)
  );

  control_law_sequencer #(.K1(32'sh0001_0000), .K2(32'sh0001_0000), .PERIOD(8), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .a1(a1), .a2(a2), .in_valid(in_valid),
    .in_ready(rdy1), .test(test), .b(b1), .b_valid(bv1), .busy(busy1),
    .overrun(ov1), .overrun_cnt(oc1)
  );

  control_law_sequencer #(.K1(32'sh0001_0000), .K2(32'sh0001_0000), .PERIOD(8), .SAT_EN(1'b0)) u_nosat (
    .clk(clk), .rst(rst), .en(en), .a1(a1), .a2(a2), .in_valid(in_valid),
    .in_ready(rdy2), .test(test), .b(b2), .b_valid(bv2), .busy(busy2),
    .overrun(ov2), .overrun_cnt(oc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; test = 1'b0; a1 = '0; a2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Wait for in_ready, accept one sample, scramble inputs, measure latency
  task automatic run_op(input logic [31:0] x1, input logic [31:0] x2, input logic t, output int lat);
    int n;
    a1 = x1; a2 = x2; test = t; in_valid = 1'b1;
    n = 0;
    while (rdy0 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (rdy0 !== 1'b1) begin lat = -1; in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0; test = ~t; a1 = 32'h5A5A_5A5A; a2 = 32'hA5A5_A5A5;
    lat = 0;
    while (bv0 !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
    test = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (b0 !== 32'h0) begin errors++; $display("FAIL reset_b: got %h expected %h", b0, 32'h0); end
    checks++; if ({bv0, rdy0, busy0, ov0} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bv0, rdy0, busy0, ov0}); end
    checks++; if (oc0 !== 16'h0) begin errors++; $display("FAIL reset_ovcnt: got %h expected 0000", oc0); end
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    a1 = 32'h0001_0000; a2 = 32'h0001_0000; in_valid = 1'b1; en = 1'b1;
    n = 0;
    while (rdy0 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 8) begin errors++; $display("FAIL basic_first_tick: got %0d cycles expected 8", n); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy_wait: got %b expected 1", busy0); end
    @(posedge clk); #1;
    checks++; if ({rdy0, busy0, bv0} !== 3'b010) begin errors++; $display("FAIL basic_mul1: got %b expected 010", {rdy0, busy0, bv0}); end
    @(posedge clk); #1;
    checks++; if (bv0 !== 1'b0) begin errors++; $display("FAIL basic_early_valid2: got %b expected 0", bv0); end
    @(posedge clk); #1;
    checks++; if ({busy0, bv0} !== 2'b10) begin errors++; $display("FAIL basic_out: got %b expected 10", {busy0, bv0}); end
    @(posedge clk); #1;
    checks++; if (bv0 !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bv0); end
    checks++; if (b0 !== 32'hFFFF_6667) begin errors++; $display("FAIL basic_b: got %h expected %h", b0, 32'hFFFF_6667); end
    checks++; if (b1 !== 32'h0002_0000) begin errors++; $display("FAIL basic_b_unity: got %h expected %h", b1, 32'h0002_0000); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b expected 0", busy0); end
    @(posedge clk); #1;
    checks++; if (bv0 !== 1'b0 || b0 !== 32'hFFFF_6667) begin errors++; $display("FAIL basic_hold: got valid=%b b=%h expected 0 FFFF6667", bv0, b0); end
    in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    int lat;
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sat_pos_latency: got %0d expected 3", lat); end
    checks++; if (b1 !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_pos: got %h expected 7FFFFFFF", b1); end
    checks++; if (b2 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL trunc_pos: got %h expected FFFFFFFE", b2); end
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
    checks++; if (b1 !== 32'h8000_0000) begin errors++; $display("FAIL sat_neg: got %h expected 80000000", b1); end
    checks++; if (b2 !== 32'h0000_0000) begin errors++; $display("FAIL trunc_neg: got %h expected 00000000", b2); end
  endtask

  task automatic test_test_mode();
    int lat;
    run_op(32'h0002_0000, 32'h0001_0000, 1'b1, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL test_latency: got %0d expected 3", lat); end
    checks++; if (b0 !== 32'h0003_0000) begin errors++; $display("FAIL test_b: got %h expected 00030000", b0); end
    checks++; if (b1 !== 32'h0003_0000) begin errors++; $display("FAIL test_b_sat: got %h expected 00030000", b1); end
    run_op(32'h7FFF_FFFF, 32'h0, 1'b1, lat);
    checks++; if (b1 !== 32'h8000_FFFF) begin errors++; $display("FAIL test_wrap: got %h expected 8000FFFF", b1); end
    run_op(32'h0001_0000, 32'h0001_0000, 1'b0, lat);
    checks++; if (b0 !== 32'hFFFF_6667) begin errors++; $display("FAIL test_off_again: got %h expected FFFF6667", b0); end
  endtask

  task automatic test_overrun();
    int n;
    int lat;
    do_reset();
    a1 = 32'h0001_0000; a2 = 32'h0001_0000; en = 1'b1;
    n = 0;
    while (rdy0 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    n = 0;
    while (ov0 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 8) begin errors++; $display("FAIL ovr_timing: got %0d cycles expected 8", n); end
    checks++; if (oc0 !== 16'd1) begin errors++; $display("FAIL ovr_cnt: got %0d expected 1", oc0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL ovr_still_wait: got %b expected 1", rdy0); end
    @(posedge clk); #1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL ovr_pulse_width: got %b expected 0", ov0); end
    run_op(32'h0001_0000, 32'h0001_0000, 1'b0, lat);
    checks++; if (lat !== 3 || b0 !== 32'hFFFF_6667) begin errors++; $display("FAIL ovr_recover: got lat=%0d b=%h expected 3 FFFF6667", lat, b0); end
    checks++; if (oc0 !== 16'd1) begin errors++; $display("FAIL ovr_cnt_hold: got %0d expected 1", oc0); end
  endtask

  task automatic test_reset_mid();
    int n;
    int lat;
    logic seen;
    a1 = 32'h0002_0000; a2 = 32'h0001_0000; test = 1'b0; in_valid = 1'b1;
    n = 0;
    while (rdy0 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checks++; if (b0 !== 32'h0 || bv0 !== 1'b0) begin errors++; $display("FAIL rstmid_b: got b=%h valid=%b expected 0 0", b0, bv0); end
    checks++; if ({busy0, rdy0} !== 2'b00) begin errors++; $display("FAIL rstmid_state: got %b expected 00", {busy0, rdy0}); end
    checks++; if (oc0 !== 16'd0) begin errors++; $display("FAIL rstmid_ovcnt: got %0d expected 0", oc0); end
    @(posedge clk); #1 rst = 1'b0;
    n = 0; seen = 1'b0;
    while (rdy0 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; if (bv0 === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid: got %b expected 0", seen); end
    checks++; if (n !== 8) begin errors++; $display("FAIL rstmid_restart: got %0d cycles expected 8", n); end
    run_op(32'h0002_0000, 32'h0001_0000, 1'b0, lat);
    checks++; if (lat !== 3 || b0 !== 32'hFFFF_3334) begin errors++; $display("FAIL rstmid_after: got lat=%0d b=%h expected 3 FFFF3334", lat, b0); end
  endtask

  task automatic test_en_drop();
    int n;
    int lat;
    logic seen;
    do_reset();
    a1 = 32'h0002_0000; a2 = 32'h0001_0000; in_valid = 1'b1; en = 1'b1;
    n = 0;
    while (rdy0 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; en = 1'b0;
    lat = 0;
    while (bv0 !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 3 || b0 !== 32'hFFFF_3334) begin errors++; $display("FAIL endrop_complete: got lat=%0d b=%h expected 3 FFFF3334", lat, b0); end
    seen = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rdy0 !== 1'b0 || busy0 !== 1'b0 || ov0 !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL endrop_quiet: got activity=%b expected 0", seen); end
    en = 1'b1;
    n = 0;
    while (rdy0 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 8) begin errors++; $display("FAIL endrop_restart: got %0d cycles expected 8", n); end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; test = 1'b0; a1 = '0; a2 = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_test_mode();
    test_overrun();
    test_reset_mid();
    test_en_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
